// File: rtl/array_28_ctrl.sv
// Request/response front end for a 1024x64 single-port SRAM (array_28_ext).
// Zero-fills the array after reset, then serves reads through a 2-entry credit-managed response FIFO.
module array_28_ctrl #(
  parameter bit INIT_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        init_done,
  output logic [9:0]  RW0_addr,
  output logic        RW0_en,
  output logic        RW0_wmode,
  output logic [63:0] RW0_wdata,
  input  logic [63:0] RW0_rdata
);

  typedef enum logic [1:0] {BOOT, INIT, RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  init_cnt;
  logic        inflight;
  logic [1:0]  occ;
  logic        wr_ptr, rd_ptr;
  logic [63:0] fifo_q [2];

  logic        run, req_acc, rd_acc, deq;
  logic [2:0]  credit;

  assign run        = (state_q == RUN);
  assign init_done  = run;
  assign resp_valid = (occ != 2'd0);
  assign resp_rdata = fifo_q[rd_ptr];
  assign deq        = resp_valid && resp_ready;

  // Slots committed after this edge: queued + in flight - leaving now.
  assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
  assign req_ready = run && (credit < 3'd2);
  assign req_acc   = req_valid && req_ready;
  assign rd_acc    = req_acc && !req_write;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = INIT_EN ? INIT : RUN;
      INIT:    if (init_cnt == 10'h3FF) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = 10'd0;
    RW0_wdata = 64'd0;
    if (state_q == INIT) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = init_cnt;
    end else if (run) begin
      RW0_en    = req_acc;
      RW0_wmode = req_write;
      RW0_addr  = req_addr;
      RW0_wdata = req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BOOT;
      init_cnt <= 10'd0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + 10'd1;
      inflight <= rd_acc;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (deq)      rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, deq};
    end
  end

  // SRAM data is only meaningful the cycle after a read enable, so capture is gated by inflight.
  always_ff @(posedge clock) begin
    if (inflight) fifo_q[wr_ptr] <= RW0_rdata;
  end

endmodule

// File: tb/tb_array_28_ctrl.sv
// Directed bench for array_28_ctrl with a behavioural read-first SRAM model on the RW0 port.
module tb_array_28_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, init_done;
  logic [63:0] resp_rdata;
  logic [9:0]  RW0_addr;
  logic        RW0_en, RW0_wmode;
  logic [63:0] RW0_wdata, RW0_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_28_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  logic [63:0] mem [1024];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
      else           RW0_rdata     <= mem[RW0_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [9:0] a,
                       input logic [63:0] d, input logic rr);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 0);
    chk({tag, "_req_ready"},  64'(req_ready), 0);
    chk({tag, "_init_done"},  64'(init_done), 0);
    chk({tag, "_rw0"}, {RW0_wdata ^ 64'(RW0_addr)}, 0);
    chk({tag, "_rw0_ctl"}, 64'({RW0_en, RW0_wmode, RW0_addr != 10'd0}), 0);
  endtask

  // Holds reset for two edges, releases mid-cycle; returns inside the BOOT cycle.
  task automatic reset_release();
    drive(0, 0, '0, '0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  // Walks BOOT and the zero-fill; stop_at >= 0 returns in the cycle writing that address.
  task automatic init_seq(input int stop_at);
    int bad = 0;
    chk("boot_en", 64'(RW0_en), 0);
    chk("boot_ready", 64'(req_ready), 0);
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (RW0_en !== 1'b1 || RW0_wmode !== 1'b1 || RW0_addr !== i[9:0] || RW0_wdata !== 64'd0 ||
          req_ready !== 1'b0 || init_done !== 1'b0 || resp_valid !== 1'b0) bad++;
      if (i == stop_at) begin
        chk("init_addr_at_stop", 64'(RW0_addr), 64'(stop_at));
        return;
      end
    end
    chk("init_seq_bad_cycles", 64'(bad), 0);
    tick();
    chk("run_init_done", 64'(init_done), 1);
    chk("run_req_ready", 64'(req_ready), 1);
    chk("run_no_resp", 64'(resp_valid), 0);
    chk("run_no_extra_write", 64'(RW0_en), 0);
  endtask

  typedef struct {
    logic v, w; logic [9:0] a; logic [63:0] d; logic rr;
    logic e_rdy, e_rv, e_en; logic [63:0] e_rd;
  } vec_t;
  vec_t vt[16];

  initial begin
    logic [63:0] expq[$];
    int bad_rdy, nresp;

    //        v  w  addr    wdata                   rr  rdy rv en  rdata
    vt[0]  = '{1, 1, 10'h3FF, 64'h0123456789ABCDEF, 1,  1,  0, 1, 64'h0};
    vt[1]  = '{1, 0, 10'h3FF, 64'h0,                1,  1,  0, 1, 64'h0};
    vt[2]  = '{0, 0, 10'h000, 64'h0,                1,  1,  0, 0, 64'h0};
    vt[3]  = '{0, 0, 10'h000, 64'h0,                1,  1,  1, 0, 64'h0123456789ABCDEF};
    vt[4]  = '{0, 0, 10'h000, 64'h0,                1,  1,  0, 0, 64'h0};
    vt[5]  = '{1, 1, 10'h005, 64'hAAAA_AAAA_0000_5555, 1, 1, 0, 1, 64'h0};
    vt[6]  = '{1, 0, 10'h005, 64'h0,                1,  1,  0, 1, 64'h0};
    vt[7]  = '{1, 1, 10'h005, 64'hBBBB_0000_BBBB_1111, 1, 1, 0, 1, 64'h0};
    vt[8]  = '{1, 0, 10'h005, 64'h0,                1,  1,  1, 1, 64'hAAAA_AAAA_0000_5555};
    vt[9]  = '{0, 0, 10'h000, 64'h0,                1,  1,  0, 0, 64'h0};
    vt[10] = '{0, 0, 10'h000, 64'h0,                1,  1,  1, 0, 64'hBBBB_0000_BBBB_1111};
    vt[11] = '{0, 0, 10'h000, 64'h0,                1,  1,  0, 0, 64'h0};
    vt[12] = '{1, 0, 10'h200, 64'h0,                1,  1,  0, 1, 64'h0};
    vt[13] = '{0, 0, 10'h000, 64'h0,                1,  1,  0, 0, 64'h0};
    vt[14] = '{0, 0, 10'h000, 64'h0,                1,  1,  1, 0, 64'h0};
    vt[15] = '{0, 0, 10'h000, 64'h0,                1,  1,  0, 0, 64'h0};

    #3 chk_reset_outs("por");
    reset_release();
    init_seq(-1);

    for (int k = 0; k < 16; k++) begin
      tick();
      drive(vt[k].v, vt[k].w, vt[k].a, vt[k].d, vt[k].rr);
      #1;
      chk($sformatf("vec%0d_ready", k), 64'(req_ready), 64'(vt[k].e_rdy));
      chk($sformatf("vec%0d_resp_valid", k), 64'(resp_valid), 64'(vt[k].e_rv));
      chk($sformatf("vec%0d_rw0_en", k), 64'(RW0_en), 64'(vt[k].e_en));
      if (vt[k].e_rv) chk($sformatf("vec%0d_rdata", k), resp_rdata, vt[k].e_rd);
    end

    // Backpressure: two credits, then stall until responses drain.
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1, 1, 10'(i), 64'hA0A0_0000_0000_0000 + 64'(i), 0); #1;
      chk("bp_write_ready", 64'(req_ready), 1);
    end
    tick(); drive(1, 0, 10'd0, '0, 0); #1; chk("bp_rd0_ready", 64'(req_ready), 1);
    tick(); drive(1, 0, 10'd1, '0, 0); #1; chk("bp_rd1_ready", 64'(req_ready), 1);
    tick(); drive(1, 0, 10'd2, '0, 0); #1; chk("bp_rd2_stall", 64'(req_ready), 0);
    tick(); #1;
    chk("bp_full_stall", 64'(req_ready), 0);
    chk("bp_full_head", resp_rdata, 64'hA0A0_0000_0000_0000);
    tick(); resp_ready = 1'b1; #1;
    chk("bp_release_ready", 64'(req_ready), 1);
    chk("bp_resp0", resp_rdata, 64'hA0A0_0000_0000_0000);
    tick(); drive(0, 0, '0, '0, 1); #1;
    chk("bp_resp1_valid", 64'(resp_valid), 1);
    chk("bp_resp1", resp_rdata, 64'hA0A0_0000_0000_0001);
    tick(); #1;
    chk("bp_resp2_valid", 64'(resp_valid), 1);
    chk("bp_resp2", resp_rdata, 64'hA0A0_0000_0000_0002);
    tick(); #1;
    chk("bp_drained", 64'(resp_valid), 0);

    // Streaming 100 reads at full rate.
    bad_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      logic [63:0] d;
      d = 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0001_0003);
      tick(); drive(1, 1, 10'h040 + 10'(i), d, 1); #1;
      if (req_ready !== 1'b1) bad_rdy++;
      expq.push_back(d);
    end
    nresp = 0;
    for (int k = 0; k < 105; k++) begin
      tick();
      if (k < 100) drive(1, 0, 10'h040 + 10'(k), '0, 1);
      else         drive(0, 0, '0, '0, 1);
      #1;
      if (k < 100 && req_ready !== 1'b1) bad_rdy++;
      if (resp_valid === 1'b1) begin
        nresp++;
        if (expq.size() == 0) chk("stream_extra_resp", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk($sformatf("stream_resp%0d", nresp - 1), resp_rdata, expq.pop_front());
      end
    end
    chk("stream_ready_drops", 64'(bad_rdy), 0);
    chk("stream_resp_count", 64'(nresp), 100);

    // Reset in the middle of the zero-fill.
    reset_release();
    init_seq(500);
    reset_n = 1'b0;
    #1 chk_reset_outs("rst_mid_init");
    reset_release();
    init_seq(-1);

    // Reset with two responses queued.
    tick(); drive(1, 0, 10'h010, '0, 0);
    tick(); drive(1, 0, 10'h011, '0, 0);
    tick(); drive(0, 0, '0, '0, 0);
    tick(); #1;
    chk("q2_resp_valid", 64'(resp_valid), 1);
    chk("q2_ready", 64'(req_ready), 0);
    reset_n = 1'b0;
    #1 chk_reset_outs("rst_queued");
    reset_release();
    init_seq(-1);
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk($sformatf("no_stale_resp%0d", k), 64'(resp_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
